mfi_check_ctrl: RTL

Sequencing controller for the formal instruction check harness. It watches the retirement stream on the MFI bus and produces the one-shot `check` strobe that tells the instruction checker which retired instruction to compare against the spec model. It sits between the core's MFI outputs and the checker's `check` input, and also exposes retirement and status signals to the cover and assert logic.

---
 rtl/mfi_ctrl_pkg.sv | 13 +
 rtl/mfi_check_ctrl_if.sv | 30 +++
 rtl/mfi_sat_counter.sv | 25 ++
 rtl/mfi_check_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/mfi_ctrl_pkg.sv
// Shared types for the MFI check sequencing controller.
package mfi_ctrl_pkg;

  localparam int unsigned MFI_CTRL_STATE_W = 2;

  typedef enum logic [MFI_CTRL_STATE_W-1:0] {
    HOLD   = 2'd0,
    WARMUP = 2'd1,
    ARMED  = 2'd2,
    DONE   = 2'd3
  } mfi_ctrl_state_e;

endpackage

// File: rtl/mfi_check_ctrl_if.sv
// Retirement stream in, check strobe and status out, for the MFI check controller.
interface mfi_check_ctrl_if #(
  parameter int unsigned CNT_W = 8
);

  logic             mfi_valid;
  logic             mfi_trap;
  logic             mfi_halt;
  logic             mfi_intr;
  logic             check_en;
  logic             allow_intr;
  logic             check;
  logic             armed;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] retire_count;

  // Harness / core side.
  modport master (
    output mfi_valid, mfi_trap, mfi_halt, mfi_intr, check_en, allow_intr,
    input  check, armed, done, timeout, retire_count
  );

  // Controller side.
  modport slave (
    input  mfi_valid, mfi_trap, mfi_halt, mfi_intr, check_en, allow_intr,
    output check, armed, done, timeout, retire_count
  );

endinterface

// File: rtl/mfi_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module mfi_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_inc_c
);

  localparam logic [W-1:0] MAX_VAL = '1;

  // Value the counter would take on an increment, pinned at all-ones.
  assign count_inc_c = (count == MAX_VAL) ? count : count + W'(1);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc_c;
    end
  end

endmodule

// File: rtl/mfi_check_ctrl.sv
// Picks the single retired instruction the formal checker compares against the spec model.
module mfi_check_ctrl
  import mfi_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned MIN_RETIRE  = 1,
  parameter int unsigned MAX_RETIRE  = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           clock,
  input  logic           reset,
  mfi_check_ctrl_if.slave bus
);

  localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_RETIRE);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_RETIRE);

  mfi_ctrl_state_e   state;
  logic              armed_q;
  logic              done_q;
  logic              timeout_q;

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_inc_unused;
  logic [CNT_W-1:0]  retire_cnt;
  logic [CNT_W-1:0]  retire_post_c;

  logic              check_c;
  logic              hold_done_c;
  logic              retire_inc_c;

  // Trap status only feeds the cover logic; it never gates the check.
  logic              trap_unused;
  assign trap_unused = bus.mfi_trap;

  assign check_c = !reset && (state == ARMED) && bus.mfi_valid && bus.check_en
                   && (bus.allow_intr || !bus.mfi_intr);

  assign hold_done_c  = (HOLD_CYCLES <= 1) || (hold_cnt == HOLD_LAST);
  assign retire_inc_c = bus.mfi_valid
                        && ((state == WARMUP) || ((state == ARMED) && !check_c));

  mfi_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clock       (clock),
    .clear       (reset),
    .inc         (state == HOLD),
    .count       (hold_cnt),
    .count_inc_c (hold_inc_unused)
  );

  mfi_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clock       (clock),
    .clear       (reset),
    .inc         (retire_inc_c),
    .count       (retire_cnt),
    .count_inc_c (retire_post_c)
  );

  // Sequencer; a check beats halt/limit, and DONE only leaves through reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HOLD;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_done_c) begin
            state <= WARMUP;
          end
        end
        WARMUP: begin
          if (bus.mfi_valid && (retire_post_c >= MIN_CNT)) begin
            state   <= ARMED;
            armed_q <= 1'b1;
          end
        end
        ARMED: begin
          if (check_c) begin
            state     <= DONE;
            armed_q   <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (bus.mfi_valid && (bus.mfi_halt || (retire_post_c >= MAX_CNT))) begin
            state     <= DONE;
            armed_q   <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.check        = check_c;
  assign bus.armed        = armed_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.retire_count = retire_cnt;

endmodule
